// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared types and defaults for the DELAY pulse generator and monitor
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int N_DEFAULT     = 400000;
  localparam int CBITS_DEFAULT = 19;

  // Pulse spacing produced by a generator with terminal count n.
  function automatic int period(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/pulse_interval_ctr.sv
// rtl/pulse_interval_ctr.sv - saturating cycle counter measuring the gap between pulses
module pulse_interval_ctr #(
  parameter int CBITS = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CBITS-1:0] ivl
);

  // A pulse cycle restarts the count at 1 so the value seen on the next pulse equals the spacing.
  always_ff @(posedge clk) begin
    if (rst) begin
      ivl <= '0;
    end else if (clr) begin
      ivl <= CBITS'(1);
    end else if (en && (ivl != '1)) begin
      ivl <= ivl + 1'b1;
    end
  end

endmodule

// File: rtl/delay_pulse_monitor.sv
// rtl/delay_pulse_monitor.sv - lock/early/late checker for the periodic DELAY pulse
module delay_pulse_monitor
  import delay_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int CBITS    = CBITS_DEFAULT,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  output logic       locked,
  output logic       early_err,
  output logic       late_err,
  output logic [7:0] err_cnt
);

  localparam int P     = period(N);
  localparam int GBITS = $clog2(LOCK_CNT + 1);

  localparam logic [CBITS-1:0] S_MIN = CBITS'(P - TOL);
  localparam logic [CBITS-1:0] S_MAX = CBITS'(P + TOL);
  localparam logic [GBITS-1:0] G_LAST = GBITS'(LOCK_CNT - 1);

  mon_state_t       state;
  logic [GBITS-1:0] good;
  logic [CBITS-1:0] ivl;
  logic             in_win;
  logic             early;
  logic             timeout;

  // The counter only runs while a pulse train is being tracked; IDLE freezes it.
  pulse_interval_ctr #(.CBITS(CBITS)) u_ivl (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .clr (sig),
    .ivl (ivl)
  );

  assign in_win  = (ivl >= S_MIN) && (ivl <= S_MAX);
  assign early   = ivl < S_MIN;
  assign timeout = !sig && (ivl == S_MAX);

  // Lock FSM with registered status, one-cycle error strobes and saturating fault count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      good      <= '0;
      locked    <= 1'b0;
      early_err <= 1'b0;
      late_err  <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      early_err <= 1'b0;
      late_err  <= 1'b0;
      locked    <= (state == LOCKED);
      case (state)
        IDLE: begin
          if (sig) begin
            state <= ACQ;
            good  <= '0;
          end
        end
        ACQ: begin
          if (sig) begin
            if (in_win) begin
              if (good == G_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
                good   <= '0;
              end else begin
                good <= good + 1'b1;
              end
            end else begin
              good <= '0;
            end
          end else if (timeout) begin
            state <= IDLE;
            good  <= '0;
          end
        end
        LOCKED: begin
          if (sig) begin
            if (!in_win) begin
              // Spacing above the window is unreachable here: the timeout fires first.
              state     <= ACQ;
              locked    <= 1'b0;
              good      <= '0;
              early_err <= early;
              if (early && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            end
          end else if (timeout) begin
            state    <= IDLE;
            locked   <= 1'b0;
            good     <= '0;
            late_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
          good   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_pulse_monitor.sv
// tb/tb_delay_pulse_monitor.sv - self-checking bench for delay_pulse_monitor
module tb_delay_pulse_monitor;

  localparam int NB = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sig, locked, early_err, late_err;
  logic [7:0] err_cnt;
  logic       rst_b, sig_b, locked_b, early_b, late_b;
  logic [7:0] err_cnt_b;
  logic       rst_s, sig_s, locked_s, early_s, late_s;
  logic [7:0] err_cnt_s;

  delay_pulse_monitor #(.N(6), .CBITS(4), .TOL(1), .LOCK_CNT(3)) dut (
    .clk(clk), .rst(rst), .sig(sig), .locked(locked),
    .early_err(early_err), .late_err(late_err), .err_cnt(err_cnt)
  );

  delay_pulse_monitor #(.N(NB), .CBITS(12), .TOL(0), .LOCK_CNT(4)) dut_b (
    .clk(clk), .rst(rst_b), .sig(sig_b), .locked(locked_b),
    .early_err(early_b), .late_err(late_b), .err_cnt(err_cnt_b)
  );

  delay_pulse_monitor #(.N(2), .CBITS(3), .TOL(0), .LOCK_CNT(1)) dut_s (
    .clk(clk), .rst(rst_s), .sig(sig_s), .locked(locked_s),
    .early_err(early_s), .late_err(late_s), .err_cnt(err_cnt_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       locked;
    logic       early;
    logic       late;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int         gap;
    logic       lk_idle;
    logic       lk_after;
    logic       early;
    logic [7:0] cnt_idle;
    logic [7:0] cnt_after;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the main DUT; the expectation is for outputs after that edge.
  task automatic step(input logic r, input logic s, input logic el, input logic ee,
                      input logic elt, input logic [7:0] ec);
    exp_t e;
    rst = r;
    sig = s;
    e.locked = el; e.early = ee; e.late = elt; e.cnt = ec;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    check_bit("locked", locked, e.locked);
    check_bit("early_err", early_err, e.early);
    check_bit("late_err", late_err, e.late);
    check_byte("err_cnt", err_cnt, e.cnt);
  endtask

  function automatic void add(input int g, input logic li, input logic la, input logic ee,
                              input logic [7:0] ci, input logic [7:0] ca);
    vec_t v;
    v.gap = g; v.lk_idle = li; v.lk_after = la; v.early = ee;
    v.cnt_idle = ci; v.cnt_after = ca;
    tbl.push_back(v);
  endfunction

  // A gap of g: g-1 quiet cycles then a pulse, so the pulse sees spacing g.
  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 1; j < tbl[i].gap; j++)
        step(1'b0, 1'b0, tbl[i].lk_idle, 1'b0, 1'b0, tbl[i].cnt_idle);
      step(1'b0, 1'b1, tbl[i].lk_after, tbl[i].early, 1'b0, tbl[i].cnt_after);
    end
    tbl.delete();
  endtask

  initial begin
    int gcnt, pulses, errs, want;
    rst = 1'b1; sig = 1'b0;
    rst_b = 1'b1; sig_b = 1'b0;
    rst_s = 1'b1; sig_s = 1'b0;

    // Reset and acquisition, tolerated jitter, early fault and relock with ACQ restarts.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(3, 0, 0, 0, 0, 0);
    add(7, 0, 0, 0, 0, 0);
    add(7, 0, 0, 0, 0, 0);
    add(7, 0, 1, 0, 0, 0);
    add(6, 1, 1, 0, 0, 0);
    add(8, 1, 1, 0, 0, 0);
    add(7, 1, 1, 0, 0, 0);
    add(5, 1, 0, 1, 0, 1);
    add(7, 0, 0, 0, 1, 1);
    add(4, 0, 0, 0, 1, 1);
    add(6, 0, 0, 0, 1, 1);
    add(8, 0, 0, 0, 1, 1);
    add(7, 0, 1, 0, 1, 1);
    run_table();

    // Withheld pulse while locked: late strobe on the 8th quiet cycle.
    for (int j = 1; j < 8; j++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

    // ACQ timeout is silent, then a fresh acquisition, another early fault and relock.
    add(3, 0, 0, 0, 2, 2);
    add(7, 0, 0, 0, 2, 2);
    run_table();
    for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    add(2, 0, 0, 0, 2, 2);
    add(7, 0, 0, 0, 2, 2);
    add(7, 0, 0, 0, 2, 2);
    add(7, 0, 1, 0, 2, 2);
    add(5, 1, 0, 1, 2, 3);
    add(7, 0, 0, 0, 3, 3);
    add(7, 0, 0, 0, 3, 3);
    add(7, 0, 1, 0, 3, 3);
    run_table();

    // Reset while locked with three faults, then a stuck-high input never locks.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int j = 0; j < 20; j++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(7, 0, 0, 0, 0, 0);
    add(7, 0, 0, 0, 0, 0);
    add(7, 0, 1, 0, 0, 0);
    run_table();
    sig = 1'b0;

    // Long period driven by a modelled generator: lock on the 5th pulse, no faults after.
    rst_b = 1'b0;
    gcnt = 0; pulses = 0; errs = 0;
    for (int c = 0; c < 15 * (NB + 1); c++) begin
      sig_b = (gcnt == NB);
      tick();
      if (early_b || late_b) errs++;
      if (sig_b) begin
        pulses++;
        check_bit("big_locked", locked_b, pulses >= 5);
      end
      gcnt = (gcnt == NB) ? 0 : gcnt + 1;
    end
    sig_b = 1'b0;
    check_byte("big_err_strobes", 8'(errs), 8'd0);
    check_byte("big_err_cnt", err_cnt_b, 8'd0);

    // Fault counter saturation: repeated lock / timeout rounds on a 3-cycle period.
    rst_s = 1'b0;
    for (int r = 1; r <= 260; r++) begin
      sig_s = 1'b1; tick();
      sig_s = 1'b0; tick(); tick();
      sig_s = 1'b1; tick();
      check_bit("sat_locked", locked_s, 1'b1);
      sig_s = 1'b0; tick(); tick(); tick();
      check_bit("sat_late", late_s, 1'b1);
      want = (r > 255) ? 255 : r;
      check_byte("sat_err_cnt", err_cnt_s, 8'(want));
    end
    tick();
    check_bit("sat_late_clear", late_s, 1'b0);
    check_byte("sat_err_cnt_hold", err_cnt_s, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
